mips_mc: RTL
============

MIPS_MC -- requirements
Module: mips_mc

Interface
REQ-001 Parameter IMEM_BYTES, default 128, instruction memory depth in bytes (power of 2, min 16).
REQ-002 Parameter DMEM_BYTES, default 128, data memory depth in bytes (power of 2, min 16).
REQ-003 Parameter RESET_PC, default 32'h0, PC value loaded on reset (word aligned).
REQ-004 Parameter CNT_W, default 32, width of retired-instruction counter.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset; rst=0 resets immediately, release synchronous to clk.
REQ-007 run  input  1  1 = core advances one FSM step per cycle; 0 = all core state frozen.
REQ-008 imem_we  input  1  instruction-memory word write strobe (loader port).
REQ-009 imem_addr  input  $clog2(IMEM_BYTES)  byte address of loader write; bits[1:0] ignored.
REQ-010 imem_wdata  input  32  loader word; byte 0 = bits[7:0] at lowest address (little-endian).
REQ-011 pc_o  output  32  current PC register.
REQ-012 state_o  output  3  FSM encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
REQ-013 retire  output  1  one-cycle pulse in the final cycle of each completed instruction.
REQ-014 halted  output  1  1 while FSM is in HALT.
REQ-015 instr_cnt  output  CNT_W  count of retired instructions, saturating at all-ones.

Function
REQ-016 Multi-cycle datapath: internal byte arrays imem[IMEM_BYTES], dmem[DMEM_BYTES], 32x32 register file, IR, A, B, ALUOut, MDR registers.
REQ-017 FETCH: IR <= 4 bytes at PC (little-endian); PC <= PC+4; next DECODE.
REQ-018 DECODE: A <= R[rs], B <= R[rt]; R[0] always reads 0; illegal opcode/funct -> HALT, no retire.
REQ-019 Supported: R-type ADD/SUB/AND/OR/NOR/XOR/SLT (funct 20/22/24/25/27/26/2A hex), ADDI 08, LW 23, SW 2B, BEQ 04, BNE 05, J 02.
REQ-020 EXEC: ALU per opcode/funct; ADD/SUB wrap mod 2^32; SLT signed compare; imm sign-extended 16->32.
REQ-021 BEQ/BNE: taken target = (PC already +4) + (sext(imm)<<2); retire in EXEC.
REQ-022 J: PC <= {PC[31:28], IR[25:0], 2'b00}; retire in EXEC.
REQ-023 R-type/ADDI: EXEC -> WB; LW/SW: EXEC -> MEM.
REQ-024 MEM: LW MDR <= 4 dmem bytes at ALUOut -> WB; SW writes B little-endian to dmem at ALUOut, retire in MEM -> FETCH.
REQ-025 WB: write rd (R-type), rt (ADDI, LW); writes to R[0] discarded; retire -> FETCH.
REQ-026 Latency in run=1 cycles: branch/J 3, R-type/ADDI/SW 4, LW 5.
REQ-027 HALT on: PC[1:0]!=0 or PC+3 >= IMEM_BYTES at FETCH; data addr[1:0]!=0 or addr+3 >= DMEM_BYTES at MEM (no access performed, no retire).
REQ-028 HALT is sticky until reset; PC, registers, memories hold.
REQ-029 run=0: FSM, PC, regfile, dmem, instr_cnt, retire all frozen (retire=0); resumes exactly where stopped.
REQ-030 imem_we honoured only when run=0 or halted; otherwise ignored; write visible to next FETCH.
REQ-031 instr_cnt increments with each retire; holds at 2^CNT_W-1.

Reset
REQ-032 rst=0: state=FETCH, PC=RESET_PC, retire=0, halted=0, instr_cnt=0, regfile and dmem cleared to 0, IR/A/B/ALUOut/MDR=0.
REQ-033 imem NOT cleared by reset; rst asserted mid-instruction aborts it with no partial register/memory write after assertion.

Verification
REQ-034 Load ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; run=1 -> r3=12 after 12 cycles, instr_cnt=3, 3 retire pulses.
REQ-035 SW r3,8(r0); LW r4,8(r0) -> dmem[8..11]=0C,00,00,00; r4=12; LW takes 5 cycles.
REQ-036 BEQ r1,r1,+2 at PC=0x10 -> PC=0x1C after 3 cycles; BNE r1,r1 -> PC=0x14; J 0x20 -> PC=0x80.
REQ-037 Opcode 3F, or LW at addr 0x7E -> halted=1, state_o=7, no retire, dmem/regs unchanged; stays until rst=0.
REQ-038 Drop run for 5 cycles mid-LW -> state_o/pc_o constant, retire=0; completion count unchanged otherwise.
REQ-039 ADDI r0,r0,9 then ADD r5,r0,r0 -> r5=0; rst=0 during EXEC -> PC=RESET_PC, instr_cnt=0 immediately.

Source files
------------

// File: rtl/mips_mc.sv
// Multi-cycle MIPS subset core with internal byte-addressed instruction and data
// memories, a run/freeze control and a saturating retired-instruction counter.
module mips_mc #(
  parameter int          IMEM_BYTES = 128,
  parameter int          DMEM_BYTES = 128,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_BYTES)-1:0] imem_addr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc_o,
  output logic [2:0]                    state_o,
  output logic                          retire,
  output logic                          halted,
  output logic [CNT_W-1:0]              instr_cnt
);

  localparam int IA_W = $clog2(IMEM_BYTES);
  localparam int DA_W = $clog2(DMEM_BYTES);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     pc, ir, a, b, alu_out, mdr;
  logic [CNT_W-1:0] cnt;
  logic [31:0]     rf   [32];
  logic [7:0]      imem [IMEM_BYTES];
  logic [7:0]      dmem [DMEM_BYTES];

  // Instruction fields
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] sext_imm;

  assign opcode   = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign sext_imm = {{16{ir[15]}}, ir[15:0]};

  logic is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, legal;
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);

  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: legal = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT};
      OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Fetch: bounds check done in 33 bits so PC values near 2^32 cannot wrap into range
  logic            fetch_ok;
  logic [IA_W-1:2] fetch_idx;
  logic [31:0]     fetch_word;
  assign fetch_ok   = (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd3) < 33'(IMEM_BYTES));
  assign fetch_idx  = pc[IA_W-1:2];
  assign fetch_word = {imem[{fetch_idx, 2'b11}], imem[{fetch_idx, 2'b10}],
                       imem[{fetch_idx, 2'b01}], imem[{fetch_idx, 2'b00}]};

  // Data access address comes from ALUOut computed in EXEC
  logic            mem_ok;
  logic [DA_W-1:2] data_idx;
  logic [31:0]     load_word;
  assign mem_ok    = (alu_out[1:0] == 2'b00) && (({1'b0, alu_out} + 33'd3) < 33'(DMEM_BYTES));
  assign data_idx  = alu_out[DA_W-1:2];
  assign load_word = {dmem[{data_idx, 2'b11}], dmem[{data_idx, 2'b10}],
                      dmem[{data_idx, 2'b01}], dmem[{data_idx, 2'b00}]};

  logic [31:0] rf_rs, rf_rt;
  assign rf_rs = (rs == 5'd0) ? 32'd0 : rf[rs];
  assign rf_rt = (rt == 5'd0) ? 32'd0 : rf[rt];

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  logic [31:0] alu_res;
  always_comb begin
    alu_res = '0;
    if (is_rtype) begin
      case (funct)
        FN_ADD:  alu_res = a + b;
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_XOR:  alu_res = a ^ b;
        FN_NOR:  alu_res = ~(a | b);
        FN_SLT:  alu_res = {31'd0, $signed(a) < $signed(b)};
        default: alu_res = '0;
      endcase
    end else begin
      alu_res = a + sext_imm;
    end
  end

  logic        br_taken;
  logic [31:0] br_target, j_target;
  assign br_taken  = (is_beq && (a == b)) || (is_bne && (a != b));
  assign br_target = pc + {sext_imm[29:0], 2'b00};
  assign j_target  = {pc[31:28], ir[25:0], 2'b00};

  logic [4:0]  wb_dst;
  logic [31:0] wb_val;
  assign wb_dst = is_rtype ? rd : rt;
  assign wb_val = is_lw ? mdr : alu_out;

  logic retire_c;
  always_comb begin
    state_nxt = state;
    retire_c  = 1'b0;
    case (state)
      S_FETCH:  state_nxt = fetch_ok ? S_DECODE : S_HALT;
      S_DECODE: state_nxt = legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (is_beq || is_bne || is_j) begin
          state_nxt = S_FETCH;
          retire_c  = 1'b1;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_ok) begin
          state_nxt = S_HALT;
        end else if (is_lw) begin
          state_nxt = S_WB;
        end else begin
          state_nxt = S_FETCH;
          retire_c  = 1'b1;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        retire_c  = 1'b1;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      cnt     <= '0;
    end else if (run) begin
      state <= state_nxt;
      if (retire_c && (cnt != {CNT_W{1'b1}})) cnt <= cnt + CNT_W'(1);
      case (state)
        S_FETCH: begin
          if (fetch_ok) begin
            ir <= fetch_word;
            pc <= pc + 32'd4;
          end
        end
        S_DECODE: begin
          a <= rf_rs;
          b <= rf_rt;
        end
        S_EXEC: begin
          if (is_j)          pc <= j_target;
          else if (br_taken) pc <= br_target;
          else               alu_out <= alu_res;
        end
        S_MEM: begin
          if (is_lw && mem_ok) mdr <= load_word;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (run && (state == S_WB) && (wb_dst != 5'd0)) begin
      rf[wb_dst] <= wb_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_BYTES; i++) dmem[i] <= '0;
    end else if (run && (state == S_MEM) && is_sw && mem_ok) begin
      dmem[{data_idx, 2'b00}] <= b[7:0];
      dmem[{data_idx, 2'b01}] <= b[15:8];
      dmem[{data_idx, 2'b10}] <= b[23:16];
      dmem[{data_idx, 2'b11}] <= b[31:24];
    end
  end

  // NOTE: instruction memory has no reset so a loaded program survives rst.
  logic [IA_W-1:2] load_idx;
  assign load_idx = imem_addr[IA_W-1:2];
  always_ff @(posedge clk) begin
    if (imem_we && (!run || (state == S_HALT))) begin
      imem[{load_idx, 2'b00}] <= imem_wdata[7:0];
      imem[{load_idx, 2'b01}] <= imem_wdata[15:8];
      imem[{load_idx, 2'b10}] <= imem_wdata[23:16];
      imem[{load_idx, 2'b11}] <= imem_wdata[31:24];
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^imem_addr[1:0];

  assign pc_o      = pc;
  assign state_o   = state;
  assign retire    = run && retire_c;
  assign halted    = (state == S_HALT);
  assign instr_cnt = cnt;

endmodule
